// File: rtl/alu_div_sequencer_if.sv
// Bundles the divide request/result signals and the shared ALU port.
// The sequencer sits on the slave side; requester, EX stage and ALU sit on master.
// Plain wires only; timing is defined by the sequencer itself.
interface alu_div_sequencer_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [2:0]  ex_funct;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_funct;
  logic [31:0] alu_out;
  logic        alu_carry;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, ex_op1, ex_op2, ex_funct,
    output alu_out, alu_carry,
    input  alu_op1, alu_op2, alu_funct, busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, ex_op1, ex_op2, ex_funct,
    input  alu_out, alu_carry,
    output alu_op1, alu_op2, alu_funct, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle restoring divider that borrows the EX-stage ALU (unsigned/signed, div-by-zero flag).
// Latency start->done: 33 cycles unsigned, 37 signed, 1 for a zero divisor.
// Stalls the pipeline via busy; start is ignored unless IDLE, requester holds it until done.
module alu_div_sequencer #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF
) (
  input logic              clk,
  input logic              rst,
  alu_div_sequencer_if.slave bus
);

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_DIV, S_NEG_Q, S_NEG_R, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  // q_q holds the dividend, then |A|, then the shifting quotient
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               sa_q, sa_d, sb_q, sb_d, sg_q, sg_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   shift_s;
  logic               take_sub;
  logic [WIDTH-1:0]   q_shift;
  logic [WIDTH-1:0]   r_next;

  // One restoring step: the shifted-out remainder msb forces a subtract since
  // the 33-bit partial remainder then always exceeds a 32-bit divisor.
  assign shift_s  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign take_sub = r_q[WIDTH-1] | ~bus.alu_carry;
  assign q_shift  = {q_q[WIDTH-2:0], take_sub};
  assign r_next   = take_sub ? bus.alu_out : shift_s;

  // State and datapath registers; reset abandons any divide in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sg_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sg_q    <= sg_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) state_d = S_DONE;
          else if (bus.is_signed) state_d = S_NEG_A;
          else state_d = S_DIV;
        end
      end
      S_NEG_A: state_d = S_NEG_B;
      S_NEG_B: state_d = S_DIV;
      S_DIV:   if (cnt_q == 5'd31) state_d = sg_q ? S_NEG_Q : S_DONE;
      S_NEG_Q: state_d = S_NEG_R;
      S_NEG_R: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU ownership mux and status outputs
  always_comb begin
    bus.alu_op1   = bus.ex_op1;
    bus.alu_op2   = bus.ex_op2;
    bus.alu_funct = bus.ex_funct;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      S_NEG_A: begin
        bus.alu_op1 = '0; bus.alu_op2 = q_q; bus.alu_funct = sa_q ? FN_SUB : FN_ADD; bus.busy = 1'b1;
      end
      S_NEG_B: begin
        bus.alu_op1 = '0; bus.alu_op2 = b_q; bus.alu_funct = sb_q ? FN_SUB : FN_ADD; bus.busy = 1'b1;
      end
      S_DIV: begin
        bus.alu_op1 = shift_s; bus.alu_op2 = b_q; bus.alu_funct = FN_SUB; bus.busy = 1'b1;
      end
      S_NEG_Q: begin
        bus.alu_op1 = '0; bus.alu_op2 = q_q; bus.alu_funct = (sa_q ^ sb_q) ? FN_SUB : FN_ADD; bus.busy = 1'b1;
      end
      S_NEG_R: begin
        bus.alu_op1 = '0; bus.alu_op2 = r_q; bus.alu_funct = sa_q ? FN_SUB : FN_ADD; bus.busy = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath updates; result registers only change when a divide completes
  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    b_d    = b_q;
    r_d    = r_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    sg_d   = sg_q;
    dbz_d  = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quot_d = DBZ_QUOT;
            rem_d  = bus.dividend;
            dbz_d  = 1'b1;
          end else begin
            q_d   = bus.dividend;
            b_d   = bus.divisor;
            r_d   = '0;
            cnt_d = '0;
            sa_d  = bus.dividend[WIDTH-1] & bus.is_signed;
            sb_d  = bus.divisor[WIDTH-1] & bus.is_signed;
            sg_d  = bus.is_signed;
            dbz_d = 1'b0;
          end
        end
      end
      S_NEG_A: q_d = bus.alu_out;
      S_NEG_B: b_d = bus.alu_out;
      S_DIV: begin
        q_d   = q_shift;
        r_d   = r_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31 && !sg_q) begin
          quot_d = q_shift;
          rem_d  = r_next;
        end
      end
      S_NEG_Q: q_d = bus.alu_out;
      S_NEG_R: begin
        r_d    = bus.alu_out;
        quot_d = q_q;
        rem_d  = bus.alu_out;
      end
      default: ;
    endcase
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
- Multi-cycle divide controller for the shared 32-bit ALU in the EX stage.
- When idle, it passes the EX stage's ALU operands and function code straight through.
- On a divide request it takes ownership of the ALU and runs a restoring division using the ALU's SUB (and ADD) functions, one iteration per cycle. It stalls the pipeline until the quotient and remainder are ready.
- Supports unsigned and signed (truncate-toward-zero) divide and flags divide-by-zero.

Parameters:
- WIDTH, 32, datapath width; must equal the ALU width (only 32 is supported).
- DBZ_QUOT, 32'hFFFF_FFFF, quotient returned on divide-by-zero.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  divide request; sampled only in IDLE.
- is_signed  input  1  1 = signed divide, 0 = unsigned; sampled with start.
- dividend  input  32  numerator; sampled with start.
- divisor  input  32  denominator; sampled with start.
- ex_op1  input  32  EX-stage ALU operand 1 (pass-through).
- ex_op2  input  32  EX-stage ALU operand 2 (pass-through).
- ex_funct  input  3  EX-stage ALU function (pass-through).
- alu_op1  output  32  to ALU op1.
- alu_op2  output  32  to ALU op2.
- alu_funct  output  3  to ALU funct (ADD=0, SUB=1).
- alu_out  input  32  ALU result.
- alu_carry  input  1  ALU bit 32; after SUB, 1 means op1 < op2 (borrow).
- busy  output  1  sequencer owns the ALU; drives the pipeline stall.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  32  registered quotient.
- remainder  output  32  registered remainder.
- div_by_zero  output  1  registered; set with done when divisor == 0.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; iteration counter=0. A divide in progress is abandoned with no done pulse.
- States: IDLE, NEG_A, NEG_B, DIV, NEG_Q, NEG_R, DONE.
- ALU mux: in IDLE and DONE, alu_op1/alu_op2/alu_funct = ex_op1/ex_op2/ex_funct (combinational). In every other state the sequencer drives all three.
- busy = 1 in NEG_A, NEG_B, DIV, NEG_Q, NEG_R; else 0. done = 1 only in DONE.
- IDLE, start=1, divisor==0: go to DONE; quotient=DBZ_QUOT, remainder=dividend, div_by_zero=1. The signed flag is ignored.
- IDLE, start=1, divisor!=0:
  - Latch operands and the signs sA=dividend[31]&is_signed, sB=divisor[31]&is_signed.
  - Clear div_by_zero.
  - Next state is NEG_A if is_signed, else DIV.
- NEG_A: ALU op1=0, op2=A, funct=SUB if sA, else ADD. Latch alu_out as |A|. Next state NEG_B.
- NEG_B: same operation on B using sB. Next state DIV.
- DIV: 32 cycles, counter 0..31; Q initialised to |A|, R initialised to 0.
  - Each cycle: msb=R[31]; S={R[30:0],Q[31]}; ALU op1=S, op2=|B|, funct=SUB.
  - If msb==1 or alu_carry==0: R<=alu_out and Q<={Q[30:0],1}.
  - Otherwise: R<=S and Q<={Q[30:0],0}.
  - The msb term covers divisors >= 2^31 (33-bit partial remainder).
  - After counter==31: go to NEG_Q if signed, else DONE.
- NEG_Q: negate Q via ALU (0-Q) if sA^sB, else ADD 0. Next state NEG_R.
- NEG_R: negate R if sA, else ADD 0. Next state DONE.
- DONE: one cycle; quotient and remainder hold until the next divide completes. Next state IDLE.
- Latency, start edge to done high: unsigned = 33 cycles; signed = 37 cycles; divide-by-zero = 1 cycle.
- start while busy or in DONE: ignored, with no queueing. The requester holds start until it sees done.
- Signed 0x80000000 / 0xFFFFFFFF: wraps to quotient 0x80000000, remainder 0. No overflow flag.
- Remainder sign follows the dividend, and |remainder| < |divisor|.

Test Plan:
- Unsigned 100 / 7 -> busy=1 for 32 cycles; done at cycle 33; quotient=14, remainder=2; the ALU sees funct=SUB throughout DIV.
- Unsigned 0xFFFFFFFF / 0x80000000 (msb path) -> quotient=1, remainder=0x7FFFFFFF.
- Signed -7 / 2 -> done at cycle 37; quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Divisor 0, dividend 0x1234 -> done the next cycle; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, busy never asserted.
- Pass-through: in IDLE, ex_op1=5, ex_op2=3, ex_funct=ADD -> alu ports mirror the EX inputs. Pulsing start during DIV changes nothing.
- Assert rst at DIV iteration 10 -> immediate IDLE; busy=0, quotient=0, no done; a following 9 / 3 yields quotient 3, remainder 0.
